// File: rtl/uart_mmio_if.sv
// Bus-side port bundle of the memory-mapped UART slave.
// The bridge drives address, byte enables, read strobe and write data.
// The UART slave returns combinational read data.
interface uart_mmio_if;
  logic [31:0] Addr;
  logic [3:0]  ByteEn;
  logic        RdEn;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (
    output Addr,
    output ByteEn,
    output RdEn,
    output Din,
    input  Dout
  );

  modport slave (
    input  Addr,
    input  ByteEn,
    input  RdEn,
    input  Din,
    output Dout
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with the following registers:
//   DATA   (0x0): write to send a byte, read to get the received byte.
//   STATUS (0x4): busy, valid and sticky error flags.
//   CTRL   (0x8): interrupt enables.
//   DIV    (0xC): baud divisor, in clk cycles per bit.
// The TX and RX state machines each latch max(DIV, 2) at the start of a frame.
// A DIV write during a frame therefore only takes effect on the next frame.
module uart_mmio #(
  parameter int DEFAULT_DIV = 217,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        sys_rstn,
  uart_mmio_if.slave  bus,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam logic [1:0]       REG_DATA   = 2'd0;
  localparam logic [1:0]       REG_STATUS = 2'd1;
  localparam logic [1:0]       REG_CTRL   = 2'd2;
  localparam logic [1:0]       REG_DIV    = 2'd3;
  localparam logic [DIV_W-1:0] DIV_RST    = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN    = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic [1:0]       w_reg;
  logic             w_wr;
  logic             w_wr_data;
  logic             w_wr_status;
  logic             w_wr_ctrl;
  logic             w_rd_clr;
  logic [DIV_W-1:0] w_eff_div;
  logic             w_unused_ok;

  assign w_reg       = bus.Addr[3:2];
  assign w_wr        = |bus.ByteEn;
  assign w_wr_data   = bus.ByteEn[0] && (w_reg == REG_DATA);
  assign w_wr_status = w_wr && (w_reg == REG_STATUS);
  assign w_wr_ctrl   = bus.ByteEn[0] && (w_reg == REG_CTRL);
  assign w_rd_clr    = bus.RdEn && (w_reg == REG_DATA);
  assign w_unused_ok = ^{bus.Addr[31:4], bus.Addr[1:0], bus.Din[31:16]};

  // CPU-visible state
  logic [DIV_W-1:0] r_div;
  logic             r_rx_ie;
  logic             r_tx_ie;
  logic [7:0]       r_rx_byte;
  logic             r_rx_valid;
  logic             r_rx_ovr;
  logic             r_rx_fe;
  logic             r_irq;

  // A divisor below 2 would leave no room for the mid-bit RX sample.
  assign w_eff_div = (r_div < DIV_MIN) ? DIV_MIN : r_div;

  // ---------------------------------------------------------------------
  // TX state machine
  // ---------------------------------------------------------------------
  uart_state_e      r_tx_state, w_tx_state_nxt;
  logic [DIV_W-1:0] r_tx_cnt,   w_tx_cnt_nxt;
  logic [DIV_W-1:0] r_tx_div,   w_tx_div_nxt;
  logic [2:0]       r_tx_bit,   w_tx_bit_nxt;
  logic [7:0]       r_tx_shift, w_tx_shift_nxt;
  logic             w_tx_busy;
  logic             w_tx_last;

  assign w_tx_busy = (r_tx_state != ST_IDLE);
  assign w_tx_last = (r_tx_cnt == r_tx_div - DIV_ONE);

  // TX state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <=.
    // Every flop then samples the pre-edge value, whatever the statement order.
    if (!sys_rstn) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= DIV_RST;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_div   <= w_tx_div_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
    end
  end

  // TX next-state: each state lasts r_tx_div cycles; data shifts out LSB first
  always_comb begin
    // NOTE: every output of this block gets a default first.
    // A path that misses an assignment would otherwise infer a latch.
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + DIV_ONE;
    w_tx_div_nxt   = r_tx_div;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    unique case (r_tx_state)
      ST_IDLE: begin
        w_tx_cnt_nxt = '0;
        if (w_wr_data) begin
          w_tx_state_nxt = ST_START;
          w_tx_shift_nxt = bus.Din[7:0];
          w_tx_div_nxt   = w_eff_div;
        end
      end
      ST_START: begin
        if (w_tx_last) begin
          w_tx_state_nxt = ST_DATA;
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_tx_last) begin
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) w_tx_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tx_last) begin
          w_tx_state_nxt = ST_IDLE;
          w_tx_cnt_nxt   = '0;
        end
      end
      default: w_tx_state_nxt = ST_IDLE;
    endcase
  end

  // Line level is decoded from registered state only, so it idles high
  always_comb begin
    uart_txd = 1'b1;
    if (r_tx_state == ST_START)     uart_txd = 1'b0;
    else if (r_tx_state == ST_DATA) uart_txd = r_tx_shift[0];
  end

  // ---------------------------------------------------------------------
  // RX input synchronizer and falling-edge detect
  // ---------------------------------------------------------------------
  logic r_rxd_meta;
  logic r_rxd_sync;
  logic r_rxd_prev;
  logic w_rx_fall;

  // Two flops for metastability, plus one history flop for edge detection
  always_ff @(posedge clk) begin
    // NOTE: these flops reset to the idle line level (high).
    // Reset must not look like a start bit.
    if (!sys_rstn) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  assign w_rx_fall = r_rxd_prev && !r_rxd_sync;

  // ---------------------------------------------------------------------
  // RX state machine
  // ---------------------------------------------------------------------
  uart_state_e      r_rx_state, w_rx_state_nxt;
  logic [DIV_W-1:0] r_rx_cnt,   w_rx_cnt_nxt;
  logic [DIV_W-1:0] r_rx_div,   w_rx_div_nxt;
  logic [2:0]       r_rx_bit,   w_rx_bit_nxt;
  logic [7:0]       r_rx_shift, w_rx_shift_nxt;
  logic             w_rx_done;
  logic             w_rx_fe_set;
  logic             w_rx_last;
  logic             w_rx_half;

  assign w_rx_last = (r_rx_cnt == r_rx_div - DIV_ONE);
  assign w_rx_half = (r_rx_cnt == (r_rx_div >> 1) - DIV_ONE);

  // RX state register
  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_div   <= DIV_RST;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_div   <= w_rx_div_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // RX next-state: half a bit to mid-start, then one full bit per sample
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + DIV_ONE;
    w_rx_div_nxt   = r_rx_div;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_done      = 1'b0;
    w_rx_fe_set    = 1'b0;
    unique case (r_rx_state)
      ST_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (w_rx_fall) begin
          w_rx_state_nxt = ST_START;
          w_rx_div_nxt   = w_eff_div;
        end
      end
      ST_START: begin
        if (w_rx_half) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = r_rxd_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_rx_last) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rxd_sync, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_rx_last) begin
          w_rx_state_nxt = ST_IDLE;
          w_rx_cnt_nxt   = '0;
          w_rx_done      = r_rxd_sync;
          w_rx_fe_set    = !r_rxd_sync;
        end
      end
      default: w_rx_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Register file, RX status flags and interrupt
  // ---------------------------------------------------------------------
  // Sticky-flag clears come before sets, so a same-cycle error still latches
  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      r_div      <= DIV_RST;
      r_rx_ie    <= 1'b0;
      r_tx_ie    <= 1'b0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_fe    <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_status) begin
        r_rx_ovr <= 1'b0;
        r_rx_fe  <= 1'b0;
      end
      if (w_rx_done) begin
        // A read that clears rx_valid frees the holding register this cycle
        if (!r_rx_valid || w_rd_clr) begin
          r_rx_byte  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_ovr <= 1'b1;
        end
      end else if (w_rd_clr) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_fe_set) r_rx_fe <= 1'b1;
      if (w_wr_ctrl) begin
        r_rx_ie <= bus.Din[0];
        r_tx_ie <= bus.Din[1];
      end
      if (w_reg == REG_DIV) begin
        if (bus.ByteEn[0]) r_div[7:0]       <= bus.Din[7:0];
        if (bus.ByteEn[1]) r_div[DIV_W-1:8] <= bus.Din[DIV_W-1:8];
      end
      r_irq <= (r_rx_ie && r_rx_valid) || (r_tx_ie && !w_tx_busy);
    end
  end

  assign IRQ = r_irq;

  // Read mux; unused bits read as zero
  always_comb begin
    bus.Dout = '0;
    unique case (w_reg)
      REG_DATA:   bus.Dout = {24'b0, r_rx_byte};
      REG_STATUS: bus.Dout = {28'b0, r_rx_fe, r_rx_ovr, r_rx_valid, w_tx_busy};
      REG_CTRL:   bus.Dout = {30'b0, r_tx_ie, r_rx_ie};
      REG_DIV:    bus.Dout = {{(32-DIV_W){1'b0}}, r_div};
      default:    bus.Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio.
// A register-access vector table is followed by hand-written serial sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_mmio;

  logic clk;
  logic sys_rstn;
  logic uart_rxd;
  logic uart_txd;
  logic IRQ;

  uart_mmio_if bus_if ();

  uart_mmio #(.DEFAULT_DIV(217), .DIV_W(16)) dut (
    .clk      (clk),
    .sys_rstn (sys_rstn),
    .bus      (bus_if.slave),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .IRQ      (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] wr_addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] rd_addr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Caller is at a falling edge; returns at the falling edge after the write edge
  task automatic bus_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] din);
    bus_if.Addr   = addr;
    bus_if.ByteEn = be;
    bus_if.Din    = din;
    @(negedge clk);
    bus_if.ByteEn = 4'h0;
  endtask

  // Checks combinational Dout, optionally pulsing RdEn through one clock edge
  task automatic bus_read(input logic [31:0] addr, input logic rd, input logic [31:0] exp,
                          input string name);
    bus_if.Addr = addr;
    bus_if.RdEn = rd;
    #1;
    check(name, bus_if.Dout, exp);
    @(negedge clk);
    bus_if.RdEn = 1'b0;
  endtask

  // Drives one 8N1 frame with 4-cycle bits; ends 40 falling edges later
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rxd = f[k];
      repeat (4) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  initial begin
    logic [9:0] tx_frame;
    logic       exp_txd;

    vecs[0]  = '{32'h0, 4'h0, 32'h0,        32'h4, 32'h0,        "rst_status"};
    vecs[1]  = '{32'h0, 4'h0, 32'h0,        32'hC, 32'd217,      "rst_div"};
    vecs[2]  = '{32'h0, 4'h0, 32'h0,        32'h0, 32'h0,        "rst_data"};
    vecs[3]  = '{32'h0, 4'h0, 32'h0,        32'h8, 32'h0,        "rst_ctrl"};
    vecs[4]  = '{32'h8, 4'h1, 32'hFFFFFFFF, 32'h8, 32'h3,        "ctrl_mask"};
    vecs[5]  = '{32'h8, 4'h2, 32'h0,        32'h8, 32'h3,        "ctrl_be1_ignored"};
    vecs[6]  = '{32'h8, 4'h1, 32'h0,        32'h8, 32'h0,        "ctrl_clear"};
    vecs[7]  = '{32'hC, 4'h1, 32'h12345678, 32'hC, 32'h78,       "div_lo_byte"};
    vecs[8]  = '{32'hC, 4'h2, 32'h0000AB00, 32'hC, 32'hAB78,     "div_hi_byte"};
    vecs[9]  = '{32'hC, 4'hC, 32'hFFFFFFFF, 32'hC, 32'hAB78,     "div_upper_be_ignored"};
    vecs[10] = '{32'h4, 4'hF, 32'hFFFFFFFF, 32'h4, 32'h0,        "status_read_only"};
    vecs[11] = '{32'h0, 4'h2, 32'hFF,       32'h4, 32'h0,        "data_be1_no_tx"};
    vecs[12] = '{32'hFFFFFFF8, 4'h1, 32'h2, 32'h8, 32'h2,        "addr_alias_ctrl"};
    vecs[13] = '{32'hC, 4'h3, 32'h4,        32'hC, 32'h4,        "div_set_4"};
    vecs[14] = '{32'h8, 4'h1, 32'h0,        32'h8, 32'h0,        "ctrl_zero"};

    sys_rstn      = 1'b0;
    uart_rxd      = 1'b1;
    bus_if.Addr   = 32'h0;
    bus_if.ByteEn = 4'h0;
    bus_if.RdEn   = 1'b0;
    bus_if.Din    = 32'h0;
    repeat (4) @(negedge clk);
    sys_rstn = 1'b1;
    @(negedge clk);
    check("rst_txd", {31'b0, uart_txd}, 32'h1);
    check("rst_irq", {31'b0, IRQ}, 32'h0);

    // Register access table
    for (int v = 0; v < 15; v++) begin
      if (vecs[v].be != 4'h0) bus_write(vecs[v].wr_addr, vecs[v].be, vecs[v].din);
      bus_read(vecs[v].rd_addr, 1'b0, vecs[v].exp, vecs[v].name);
    end

    // TX frame 0xA5 at DIV=4, with a dropped second write mid-frame
    tx_frame = {1'b1, 8'hA5, 1'b0};
    bus_write(32'h0, 4'h1, 32'hA5);
    bus_if.Addr = 32'h4;
    for (int i = 0; i < 48; i++) begin
      #1;
      exp_txd = (i < 40) ? tx_frame[i / 4] : 1'b1;
      check($sformatf("tx_line_%0d", i), {31'b0, uart_txd}, {31'b0, exp_txd});
      check($sformatf("tx_busy_%0d", i), {31'b0, bus_if.Dout[0]}, (i < 40) ? 32'h1 : 32'h0);
      if (i == 10) begin
        bus_if.Addr   = 32'h0;
        bus_if.ByteEn = 4'h1;
        bus_if.Din    = 32'hFF;
      end
      @(negedge clk);
      bus_if.ByteEn = 4'h0;
      bus_if.Addr   = 32'h4;
    end

    // RX frame 0x3C, then read-clear
    send_frame(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(32'h4, 1'b0, 32'h2,  "rx_status_valid");
    bus_read(32'h0, 1'b1, 32'h3C, "rx_data_3c");
    bus_read(32'h4, 1'b0, 32'h0,  "rx_status_cleared");

    // Overrun: 0x11 then 0x22 with no read in between
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(32'h0, 1'b0, 32'h11, "ovr_keeps_old_byte");
    bus_read(32'h4, 1'b0, 32'h6,  "ovr_status");
    bus_write(32'h4, 4'h1, 32'h0);
    bus_read(32'h4, 1'b0, 32'h2,  "ovr_cleared_by_write");
    bus_read(32'h0, 1'b1, 32'h11, "ovr_read_clear");
    bus_read(32'h4, 1'b0, 32'h0,  "ovr_status_idle");

    // Framing error: stop bit low
    send_frame(8'h55, 1'b0);
    repeat (2) @(negedge clk);
    bus_read(32'h4, 1'b0, 32'h8,  "fe_status");
    bus_read(32'h0, 1'b0, 32'h11, "fe_byte_discarded");
    bus_write(32'h4, 4'h1, 32'h0);
    bus_read(32'h4, 1'b0, 32'h0,  "fe_cleared");

    // One-cycle low glitch
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (16) @(negedge clk);
    bus_read(32'h4, 1'b0, 32'h0,  "glitch_ignored");

    // Read-clear in the same cycle as byte completion: new byte, no overrun
    send_frame(8'h6B, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(32'h4, 1'b0, 32'h2,  "pre_race_valid");
    send_frame(8'hC3, 1'b1);
    bus_read(32'h0, 1'b1, 32'h6B, "race_old_byte_shown");
    bus_read(32'h4, 1'b0, 32'h2,  "race_status_no_ovr");
    bus_read(32'h0, 1'b1, 32'hC3, "race_new_byte");
    bus_read(32'h4, 1'b0, 32'h0,  "race_status_idle");

    // TX interrupt: one cycle latency, drops while busy
    bus_write(32'h8, 4'h1, 32'h3);
    check("irq_latency", {31'b0, IRQ}, 32'h0);
    @(negedge clk);
    check("irq_tx_idle", {31'b0, IRQ}, 32'h1);
    bus_write(32'h0, 4'h1, 32'hF7);
    check("irq_still_high", {31'b0, IRQ}, 32'h1);
    @(negedge clk);
    check("irq_tx_busy", {31'b0, IRQ}, 32'h0);

    // Reset in the middle of data bit 3 (0xF7 has bit 3 low)
    repeat (16) @(negedge clk);
    check("mid_tx_bit3_low", {31'b0, uart_txd}, 32'h0);
    sys_rstn = 1'b0;
    @(negedge clk);
    bus_if.Addr = 32'h4;
    #1;
    check("rst_mid_tx_txd", {31'b0, uart_txd}, 32'h1);
    check("rst_mid_tx_status", bus_if.Dout, 32'h0);
    check("rst_mid_tx_irq", {31'b0, IRQ}, 32'h0);
    @(negedge clk);
    sys_rstn = 1'b1;
    @(negedge clk);
    bus_read(32'hC, 1'b0, 32'd217, "rst_restores_div");
    bus_read(32'h8, 1'b0, 32'h0,   "rst_restores_ctrl");

    // RX interrupt
    bus_write(32'hC, 4'h3, 32'h4);
    bus_write(32'h8, 4'h1, 32'h1);
    send_frame(8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    check("irq_rx_valid", {31'b0, IRQ}, 32'h1);
    bus_read(32'h0, 1'b1, 32'h5A, "irq_rx_data");
    @(negedge clk);
    check("irq_rx_cleared", {31'b0, IRQ}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped 8N1 UART peripheral on the system bridge, alongside the timer, GPIO and digital-tube slaves.
- Drives the board uart_txd pin, which is currently tied high, and consumes uart_rxd.
- Provides CPU-visible TX/RX data, status, control and baud-divisor registers.
- Raises a level interrupt intended for hw_int bit 1.

Parameters:
- DEFAULT_DIV, 217: reset value of the baud divisor, in clk cycles per bit (25 MHz / 115200).
- DIV_W, 16: width of the divisor register.

Ports:
- clk  in  1  system clock
- sys_rstn  in  1  reset, synchronous, active-low
- Addr  in  32  bus address; only Addr[3:2] is decoded
- ByteEn  in  4  write byte enables; any nonzero value is a write
- RdEn  in  1  asserted by the bridge for one cycle on a load to this slave
- Din  in  32  write data
- Dout  out  32  read data, combinational from Addr[3:2]
- uart_rxd  in  1  asynchronous serial input
- uart_txd  out  1  serial output, idle high
- IRQ  out  1  level interrupt

Behaviour:
- Register map (word offset: name, fields):
  - 0x0 DATA: write with ByteEn[0] loads TX byte Din[7:0]; read returns {24'b0, rx_byte}.
  - 0x4 STATUS (read-only; writes ignored): bit0 tx_busy, bit1 rx_valid, bit2 rx_ovr (sticky), bit3 rx_fe (sticky). Any write to STATUS clears bits 2 and 3.
  - 0x8 CTRL: bit0 rx_ie, bit1 tx_ie. Written when ByteEn[0]=1.
  - 0xC DIV: [15:0] divisor. ByteEn[0] writes the low byte, ByteEn[1] the high byte.
- Reset (sys_rstn=0 at posedge):
  - uart_txd=1, IRQ=0, tx_busy=0, rx_valid=0, rx_ovr=0, rx_fe=0, rx_byte=0, CTRL=0, DIV=DEFAULT_DIV.
  - Both FSMs go to IDLE, aborting any frame in flight. Reset wins over all other events.
- Effective divisor = max(DIV, 2). It is latched at each frame start, so a DIV write mid-frame only affects the next frame.
- TX FSM, states IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE:
  - A DATA write in IDLE latches the byte and enters START on the next cycle; tx_busy=1 from that cycle.
  - Each state lasts exactly div cycles. Line levels: START 0, DATA bits, STOP 1.
  - tx_busy returns to 0 on the cycle after STOP ends.
  - A DATA write while tx_busy=1 is dropped silently.
  - A frame occupies exactly 10*div cycles.
- RX input conditioning: uart_rxd passes through a 2-flop synchronizer (2-cycle latency) before the FSM.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: a synchronized 1->0 transition enters START.
  - START: at div/2 cycles, if the line is 1 (glitch) return to IDLE; otherwise move on, sampling each following bit every div cycles (mid-bit).
  - DATA: 8 samples, shifted in LSB first.
  - STOP: sample 1 -> byte complete; sample 0 -> set rx_fe and discard the byte.
  - Either way return to IDLE after the stop sample. No waiting for the line to return high beyond edge detection.
- Byte completion:
  - rx_valid=0: rx_byte<=byte, rx_valid<=1.
  - rx_valid=1: set rx_ovr, keep the old byte, drop the new one.
- Reads:
  - RdEn=1 with Addr[3:2]=0 clears rx_valid at the clock edge; Dout still shows rx_byte that cycle.
  - Same-cycle read-clear and byte completion: the new byte is loaded, rx_valid stays 1, no overrun.
- IRQ = (rx_ie & rx_valid) | (tx_ie & ~tx_busy), registered (one cycle after the cause).
- Dout for unused bits is 0.

Test Plan:
- Reset hold, then release: Dout@0x4=0, Dout@0xC=217, uart_txd=1, IRQ=0.
- DIV=4; write 0x000000A5 to DATA:
  - uart_txd is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - tx_busy is high for exactly 40 cycles.
  - A second write during the frame changes nothing.
- DIV=4; drive rxd frame 0x3C with 4-cycle bits:
  - After the stop sample, STATUS=0x2 and DATA reads 0x3C.
  - That read with RdEn clears STATUS to 0x0.
- Two frames 0x11 then 0x22 with no read:
  - DATA=0x11 and STATUS bit2=1.
  - A write to STATUS clears bit2 to 0.
- Stop bit forced 0 on frame 0x55: rx_valid stays 0, STATUS=0x8.
- 1-cycle low glitch on rxd: no state change.
- CTRL=0x3 with tx idle: IRQ=1 next cycle. Start TX: IRQ drops while tx_busy.
- Reset mid-TX at bit 3: uart_txd=1 next cycle, tx_busy=0.
